mac_share_arbiter: RTL and testbench
====================================

Name: mac_share_arbiter

Overview:
- Shares one registered multiply-accumulate datapath (DATA_OUT = A*B + C, 1-cycle registered) between NUM_REQ independent requesters.
- Each requester has a valid/ready operand port. A round-robin arbiter grants one request at a time and sequences the MAC with a small FSM.
- Results return on one valid/ready output tagged with the requester index.
- Sits between the requester blocks and the shared arithmetic unit; the MAC is built inside this block.

Parameters:
- DATA_WIDTH, 8, width of A, B, C and the result.
- NUM_REQ, 4, number of requesters (2..8).
- IDX_WIDTH, 2, requester index width; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  bit i = requester i presents operands.
- req_ready  out  NUM_REQ  bit i = requester i accepted this cycle; at most one bit high.
- req_a  in  NUM_REQ*DATA_WIDTH  operand A; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_b  in  NUM_REQ*DATA_WIDTH  operand B, same slicing.
- req_c  in  NUM_REQ*DATA_WIDTH  addend C, same slicing.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  DATA_WIDTH  (A*B + C) mod 2^DATA_WIDTH.
- res_id  out  IDX_WIDTH  index of the requester that owns the result.
- res_ovf  out  1  true result did not fit in DATA_WIDTH bits.

Behaviour:
- FSM states: IDLE, EXEC, RESULT.
- Reset (synchronous, rst=1 at a clock edge):
  - state=IDLE; res_valid=0; res_data=0; res_id=0; res_ovf=0.
  - Operand registers cleared; round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
  - Reset overrides every other event, including mid-EXEC or mid-RESULT; the in-flight result is discarded.
- Grant window: open when state=IDLE, or when state=RESULT and res_ready=1.
- Arbitration:
  - Search order is last+1, last+2, ... wrapping modulo NUM_REQ.
  - The first requester with req_valid=1 wins; req_ready[winner]=1, combinationally, in the same cycle.
  - req_ready is all-zero outside the grant window.
- On a grant:
  - Latch the winner's A, B and C slices and its index into operand registers.
  - last := winner; next state = EXEC.
- EXEC (one cycle):
  - sum = A*B + C, computed at 2*DATA_WIDTH+1 bits, unsigned.
  - res_data <= sum[DATA_WIDTH-1:0].
  - res_ovf <= |sum[2*DATA_WIDTH:DATA_WIDTH].
  - res_id <= latched index; res_valid <= 1; next state = RESULT.
- RESULT:
  - res_valid=1; res_data, res_id and res_ovf are held stable while res_ready=0.
  - With res_ready=1 and a new grant in the same cycle: next state = EXEC, res_valid deasserts for the EXEC cycle.
  - With res_ready=1 and no requester valid: next state = IDLE, res_valid=0.
- IDLE with no req_valid: stay in IDLE, pointer unchanged.
- Timing:
  - Latency: request accepted at cycle T gives res_valid at T+2.
  - Throughput: one result per 2 cycles under continuous demand with res_ready=1.
- Fairness: a continuously asserted request is granted within NUM_REQ grants.
- Requester protocol: a requester must hold its operands stable while req_valid=1 and req_ready=0. The block samples operands only in the grant cycle.
- res_ready while res_valid=0 is ignored.

Test Plan (DATA_WIDTH=8, NUM_REQ=4):
1. Single request: req_valid=0010, A=3, B=4, C=5 at cycle T -> req_ready=0010 at T; at T+2 res_valid=1, res_data=17, res_id=1, res_ovf=0.
2. Overflow: requester 2 with A=20, B=13, C=10 (sum 270) -> res_data=0x0E, res_ovf=1, res_id=2. A=B=C=255 (sum 65280) -> res_data=0x00, res_ovf=1.
3. Round-robin: req_valid=1111 held, res_ready=1, from reset -> grant order 0,1,2,3,0,1; a result every 2 cycles; never two req_ready bits high.
4. Backpressure: res_ready=0 for 5 cycles while in RESULT with req_valid=1111 -> res_data and res_id stable, req_ready=0000 throughout. Raising res_ready gives a grant in that same cycle to the next index after the last grant.
5. Reset mid-operation: assert rst during EXEC -> next cycle res_valid=0, state IDLE. With req_valid=1000 and 0001 both pending afterwards, the first grant goes to requester 0.
6. Idle hold: no req_valid for 10 cycles after a completed result -> res_valid=0, req_ready=0000; the pointer is preserved, so the next grant with req_valid=1111 goes to last+1.

Source files
------------

// File: rtl/mac_share_arbiter.sv
// Round-robin arbiter that shares one registered multiply-accumulate unit
// (A*B + C) between NUM_REQ requesters and returns tagged results.
module mac_share_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_c,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DATA_WIDTH-1:0]         res_data,
  output logic [IDX_WIDTH-1:0]          res_id,
  output logic                          res_ovf
);

  typedef enum logic [1:0] {IDLE, EXEC, RESULT} state_t;
  typedef logic [2*DATA_WIDTH:0] wide_t;

  state_t                state, state_nxt;
  logic [IDX_WIDTH-1:0]  last, op_id, win_idx, cand;
  logic [DATA_WIDTH-1:0] op_a, op_b, op_c;
  logic [DATA_WIDTH-1:0] sel_a, sel_b, sel_c;
  logic                  win_found, grant_window, grant;
  wide_t                 sum;

  // Arbitration: first valid requester searching from last+1, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_WIDTH'((int'(last) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    grant_window = (state == IDLE) || (state == RESULT && res_ready);
    grant        = grant_window && win_found;
    req_ready    = '0;
    if (grant) req_ready[win_idx] = 1'b1;
  end

  // Operand mux for the winning requester's slices.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_WIDTH'(i)) begin
        sel_a = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        sel_c = req_c[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = EXEC;
      EXEC:    state_nxt = RESULT;
      RESULT:  if (res_ready) state_nxt = grant ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Full-precision product plus addend; the top bits flag overflow.
  assign sum = wide_t'(op_a) * wide_t'(op_b) + wide_t'(op_c);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= IDX_WIDTH'(NUM_REQ - 1);
      op_id     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_c      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      res_ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        op_a  <= sel_a;
        op_b  <= sel_b;
        op_c  <= sel_c;
        op_id <= win_idx;
        last  <= win_idx;
      end
      if (state == EXEC) begin
        res_data  <= sum[DATA_WIDTH-1:0];
        res_ovf   <= |sum[2*DATA_WIDTH:DATA_WIDTH];
        res_id    <= op_id;
        res_valid <= 1'b1;
      end else if (state == RESULT && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_share_arbiter.sv
// Scoreboard bench for mac_share_arbiter: grants push expected results,
// result handshakes pop and compare them; scenario tasks add inline checks.
module tb_mac_share_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int IW = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic          ovf;
    int            due;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR*DW-1:0] req_a = '0, req_b = '0, req_c = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [DW-1:0]    res_data;
  logic [IW-1:0]    res_id;
  logic             res_ovf;

  exp_t sb_q[$];
  int   grant_q[$];
  int   gcyc_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  bit   fresh   = 1'b1;

  mac_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic set_ops(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_c[i*DW +: DW] = c;
  endtask

  // Monitor for the current cycle: scoreboard push on grant, pop on result handshake.
  task automatic observe();
    logic [2*DW:0] s;
    exp_t          e;
    vectors++;
    if ($countones(req_ready) > 1) begin
      errors++;
      $display("FAIL ready_onehot: got %b expected at most one bit", req_ready);
    end
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i]) begin
        vectors++;
        if (!req_valid[i]) begin
          errors++;
          $display("FAIL ready_without_valid: got ready bit %0d expected valid=1", i);
        end
        s = (2*DW+1)'(req_a[i*DW +: DW]) * (2*DW+1)'(req_b[i*DW +: DW])
          + (2*DW+1)'(req_c[i*DW +: DW]);
        e.data = s[DW-1:0];
        e.id   = IW'(i);
        e.ovf  = (s >> DW) != 0;
        e.due  = cyc + 2;
        sb_q.push_back(e);
        grant_q.push_back(i);
        gcyc_q.push_back(cyc);
      end
    end
    if (res_valid && fresh) begin
      vectors++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got res_valid=1 expected no pending result");
      end else if (cyc != sb_q[0].due) begin
        errors++;
        $display("FAIL latency: got result at cycle %0d expected cycle %0d", cyc, sb_q[0].due);
      end
    end
    if (res_valid && res_ready && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      vectors++;
      if (res_data !== e.data || res_id !== e.id || res_ovf !== e.ovf) begin
        errors++;
        $display("FAIL result: got data=%0h id=%0d ovf=%b expected data=%0h id=%0d ovf=%b",
                 res_data, res_id, res_ovf, e.data, e.id, e.ovf);
      end
    end
    fresh = !res_valid || res_ready;
  endtask

  task automatic step();
    #1;
    observe();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_raw();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    req_valid = '0;
    res_ready = 1'b0;
    tick_raw();
    tick_raw();
    rst = 1'b0;
    sb_q.delete();
    grant_q.delete();
    gcyc_q.delete();
    fresh = 1'b1;
  endtask

  task automatic drain();
    req_valid = '0;
    res_ready = 1'b1;
    for (int k = 0; k < 20 && (sb_q.size() != 0 || res_valid); k++) step();
    vectors++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding expected 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    vectors++;
    if (res_valid !== 1'b0 || res_data !== '0 || res_id !== '0 || res_ovf !== 1'b0
        || req_ready !== '0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b data=%0h id=%0d ovf=%b ready=%b expected all zero",
               res_valid, res_data, res_id, res_ovf, req_ready);
    end
  endtask

  task automatic test_single();
    set_ops(1, 8'd3, 8'd4, 8'd5);
    req_valid = 4'b0010;
    res_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL single_grant: got %b expected 0010", req_ready);
    end
    step();
    req_valid = '0;
    step();
    vectors++;
    if (res_valid !== 1'b1 || res_data !== 8'd17 || res_id !== 2'd1 || res_ovf !== 1'b0) begin
      errors++;
      $display("FAIL single_result: got valid=%b data=%0d id=%0d ovf=%b expected 1 17 1 0",
               res_valid, res_data, res_id, res_ovf);
    end
    drain();
  endtask

  task automatic test_overflow();
    logic [DW-1:0] va[2], vb[2], vc[2], vd[2];
    va[0] = 8'd20;  vb[0] = 8'd13;  vc[0] = 8'd10;  vd[0] = 8'h0E;
    va[1] = 8'd255; vb[1] = 8'd255; vc[1] = 8'd255; vd[1] = 8'h00;
    for (int v = 0; v < 2; v++) begin
      set_ops(2, va[v], vb[v], vc[v]);
      req_valid = 4'b0100;
      res_ready = 1'b1;
      step();
      req_valid = '0;
      step();
      vectors++;
      if (res_valid !== 1'b1 || res_data !== vd[v] || res_id !== 2'd2 || res_ovf !== 1'b1) begin
        errors++;
        $display("FAIL overflow_%0d: got valid=%b data=%0h id=%0d ovf=%b expected 1 %0h 2 1",
                 v, res_valid, res_data, res_id, res_ovf, vd[v]);
      end
      drain();
    end
  endtask

  task automatic test_round_robin();
    int exp_order[6];
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2;
    exp_order[3] = 3; exp_order[4] = 0; exp_order[5] = 1;
    reset_dut();
    for (int i = 0; i < NR; i++)
      set_ops(i, DW'($urandom), DW'($urandom), DW'($urandom));
    req_valid = 4'b1111;
    res_ready = 1'b1;
    for (int k = 0; k < 12; k++) step();
    vectors++;
    if (grant_q.size() < 6) begin
      errors++;
      $display("FAIL rr_count: got %0d grants expected at least 6", grant_q.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        vectors++;
        if (grant_q[k] != exp_order[k]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got %0d expected %0d", k, grant_q[k], exp_order[k]);
        end
      end
      for (int k = 1; k < 6; k++) begin
        vectors++;
        if (gcyc_q[k] - gcyc_q[k-1] != 2) begin
          errors++;
          $display("FAIL rr_spacing[%0d]: got %0d cycles expected 2", k, gcyc_q[k] - gcyc_q[k-1]);
        end
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    reset_dut();
    for (int i = 0; i < NR; i++)
      set_ops(i, DW'($urandom), DW'($urandom), DW'($urandom));
    req_valid = 4'b1111;
    res_ready = 1'b0;
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL bp_pending: got no expected result queued expected one");
      end else if (res_valid !== 1'b1 || req_ready !== '0 || res_data !== sb_q[0].data
                   || res_id !== sb_q[0].id) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b ready=%b data=%0h id=%0d expected 1 0000 %0h %0d",
                 k, res_valid, req_ready, res_data, res_id, sb_q[0].data, sb_q[0].id);
      end
      step();
    end
    res_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release_grant: got %b expected 0010", req_ready);
    end
    step();
    drain();
  endtask

  task automatic test_reset_mid();
    reset_dut();
    set_ops(2, 8'd7, 8'd9, 8'd1);
    set_ops(0, 8'd2, 8'd3, 8'd4);
    set_ops(3, 8'd5, 8'd6, 8'd7);
    req_valid = 4'b0100;
    res_ready = 1'b1;
    step();
    req_valid = '0;
    rst = 1'b1;
    tick_raw();
    rst = 1'b0;
    sb_q.delete();
    fresh = 1'b1;
    vectors++;
    if (res_valid !== 1'b0 || res_data !== '0) begin
      errors++;
      $display("FAIL reset_mid_clear: got valid=%b data=%0h expected 0 0", res_valid, res_data);
    end
    req_valid = 4'b1001;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_priority: got %b expected 0001", req_ready);
    end
    step();
    drain();
  endtask

  task automatic test_idle_hold();
    set_ops(2, 8'd11, 8'd12, 8'd13);
    req_valid = 4'b0100;
    res_ready = 1'b1;
    step();
    drain();
    for (int k = 0; k < 10; k++) begin
      req_valid = '0;
      #1;
      vectors++;
      if (res_valid !== 1'b0 || req_ready !== '0) begin
        errors++;
        $display("FAIL idle_hold[%0d]: got valid=%b ready=%b expected 0 0000", k, res_valid, req_ready);
      end
      step();
    end
    for (int i = 0; i < NR; i++)
      set_ops(i, DW'($urandom), DW'($urandom), DW'($urandom));
    req_valid = 4'b1111;
    #1;
    vectors++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL idle_pointer: got %b expected 1000", req_ready);
    end
    step();
    drain();
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_idle_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
